// File: rtl/qam_psc_if.sv
// qam_psc_if: symbol-in / bit-out bundle for the QAM receive parallel-to-serial
// converter.
//   sym_valid/sym_ready/sym_in : W-bit symbol handshake (upstream -> converter)
//   en                         : downstream bit-rate enable
//   Dout/dout_valid            : serial bit stream, MSB of each symbol first
// modport master : upstream/downstream side (drives symbols and en)
// modport slave  : the converter itself
interface qam_psc_if #(parameter int W = 2);
  logic         sym_valid;
  logic         sym_ready;
  logic [W-1:0] sym_in;
  logic         en;
  logic         Dout;
  logic         dout_valid;

  modport master (output sym_valid, sym_in, en,
                  input  sym_ready, Dout, dout_valid);
  modport slave  (input  sym_valid, sym_in, en,
                  output sym_ready, Dout, dout_valid);
endinterface

// File: rtl/qam_psc.sv
// qam_psc: parallel-to-serial converter for the QAM receive path.
// Accepts W-bit demapped symbols over valid/ready and shifts them out one bit
// per enabled cycle, MSB first. A one-entry holding buffer takes the next
// symbol while the current one drains, so output is gap-free under en=1.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (drops partial and held symbols)
//   bus  : qam_psc_if.slave (sym_valid/sym_ready/sym_in, en, Dout/dout_valid)
// Parameter W: bits per symbol, 1..8.
// Optional macro PSC_GRAY_EN: sym_in is Gray-coded and converted to binary at
// capture (both direct and hold load paths); undefined stores sym_in as-is.
module qam_psc #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  qam_psc_if.slave     bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_v_q, hold_v_d;

  logic           active, accept, consume, last, free;
  logic [W-1:0]   cap;

  // Value actually stored when a symbol is captured.
  always_comb begin
    cap = bus.sym_in;
`ifdef PSC_GRAY_EN
    cap[W-1] = bus.sym_in[W-1];
    for (int i = W - 2; i >= 0; i--) cap[i] = cap[i+1] ^ bus.sym_in[i];
`endif
  end

  assign active  = (state_q == SHIFT);
  assign accept  = bus.sym_valid & ~hold_v_q;
  assign consume = bus.en & active;
  assign last    = consume & (cnt_q == CW'(W - 1));
  // Shifter can take a new symbol this edge: empty or releasing its last bit.
  assign free    = ~active | last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;

    if (free && hold_v_q) begin
      // Held symbol has priority; sym_ready is low so no accept competes.
      sh_d     = hold_q;
      cnt_d    = '0;
      state_d  = SHIFT;
      hold_v_d = 1'b0;
    end else if (free && accept) begin
      // Direct load, no bubble even when coincident with the last bit.
      sh_d    = cap;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (free) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (consume) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + CW'(1);
    end

    // Shifter busy mid-symbol: park the new symbol in the holding buffer.
    if (accept && !free) begin
      hold_d   = cap;
      hold_v_d = 1'b1;
    end
  end

  assign bus.Dout       = sh_q[W-1];
  assign bus.dout_valid = active;
  assign bus.sym_ready  = ~hold_v_q;
endmodule
